// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory, shared-ALU multi-cycle RV32I datapath.
// One instruction phase per state; outputs decode from state plus IR fields and ALU flags.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic [6:0]         func7,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               RegWrite,
  output logic               instr_done,
  output logic [STATE_W-1:0] state
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC+4
  // DECODE   | branch/jump target into ALUOut, dispatch on opcode
  // MEMADR   | effective address rs1+imm
  // MEMREAD  | load data from ALUOut address
  // MEMWB    | write load data to rd
  // MEMWRITE | store rs2 to ALUOut address
  // EXECR    | register-register ALU op
  // EXECI    | register-immediate ALU op
  // ALUWB    | write ALUOut to rd
  // BRANCH   | compare rs1-rs2, load PC from ALUOut if taken
  // JAL      | PC <= target, ALUOut <= oldPC+4
  // JALR1    | target rs1+imm into ALUOut
  // JALR2    | PC <= target, ALUOut <= oldPC+4
  // LUI      | pass U-immediate through ALU
  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t st;

  // Only func7[5] distinguishes ADD from SUB; the rest of the field is don't-care here.
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  alu_dec = sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b100:  alu_dec = ALU_XOR;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH:  st <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: st <= S_MEMADR;
            OP_R:         st <= S_EXECR;
            OP_I:         st <= S_EXECI;
            OP_BR:        st <= S_BRANCH;
            OP_JAL:       st <= S_JAL;
            OP_JALR:      st <= S_JALR1;
            OP_LUI:       st <= S_LUI;
            default:      st <= S_FETCH;
          endcase
        end
        S_MEMADR:  st <= (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD: st <= S_MEMWB;
        S_EXECR:   st <= S_ALUWB;
        S_EXECI:   st <= S_ALUWB;
        S_JAL:     st <= S_ALUWB;
        S_JALR1:   st <= S_JALR2;
        S_JALR2:   st <= S_ALUWB;
        S_LUI:     st <= S_ALUWB;
        default:   st <= S_FETCH;
      endcase
    end
  end

  assign state = st;

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    case (st)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI: instr_done = 1'b0;
          default: instr_done = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_LW) ? IMM_I : IMM_S;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(func3, func7[5]);
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(func3, 1'b0);
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        instr_done = 1'b1;
        case (func3)
          3'b000:  PCWrite = zero;
          3'b001:  PCWrite = ~zero;
          3'b100:  PCWrite = sign;
          3'b101:  PCWrite = ~sign;
          default: PCWrite = 1'b0;
        endcase
      end
      S_JAL, S_JALR2: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_LUI: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = IMM_U;
        ALUControl = ALU_PASS;
      end
      default: ;
    endcase
    // Reset blocks every architectural write as soon as it is asserted.
    if (rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
